btn_repeat_pulse: RTL and testbench

Input conditioning stage that sits directly upstream of the modulo counter and drives its `en` input. It synchronises a raw asynchronous push-button, debounces it, and emits single-cycle `pulse_out` strobes. One strobe is emitted on each debounced press; while the button stays held and auto-repeat is enabled, further strobes follow at a fixed rate, so the counter advances once per strobe.

---
 rtl/btn_repeat_pulse.sv | 139 +++++++++++++
 tb/tb_btn_repeat_pulse.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/btn_repeat_pulse.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | btn_repeat_pulse: sync + debounce a push-button into press/repeat strobes |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module btn_repeat_pulse #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned TW           = 25,
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter int unsigned HOLD_CYC     = 25000000,
  parameter int unsigned REPEAT_CYC   = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  input  logic repeat_en,
  output logic pulse_out,
  output logic btn_level,
  output logic repeat_active
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PRESS_DB   = 3'd1,
    ST_HOLD       = 3'd2,
    ST_REPEAT     = 3'd3,
    ST_RELEASE_DB = 3'd4
  } state_t;

  localparam logic [TW-1:0] C_DB_LAST   = TW'(DEBOUNCE_CYC - 1);
  localparam logic [TW-1:0] C_HOLD_LAST = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] C_REP_LAST  = TW'(REPEAT_CYC - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  logic [TW-1:0]          r_timer;
  logic                   r_pulse;
  logic                   r_level;
  logic                   r_rep;

  state_t                 w_state_nxt;
  logic [TW-1:0]          w_timer_nxt;
  logic [TW-1:0]          w_timer_inc;
  logic                   w_fire;
  logic                   w_level_nxt;
  logic                   w_s;

  assign w_s         = r_sync[SYNC_STAGES-1];
  assign w_timer_inc = r_timer + TW'(1);

  // Every path that leaves a timed state, or reaches its limit, reloads the
  // timer with zero, so the shared timer never wraps.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = w_timer_inc;
    w_fire      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_timer_nxt = '0;
        if (w_s) w_state_nxt = ST_PRESS_DB;
      end
      ST_PRESS_DB: begin
        if (!w_s) begin
          w_state_nxt = ST_IDLE;
          w_timer_nxt = '0;
        end else if (r_timer == C_DB_LAST) begin
          w_state_nxt = ST_HOLD;
          w_timer_nxt = '0;
          w_fire      = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!w_s) begin
          w_state_nxt = ST_RELEASE_DB;
          w_timer_nxt = '0;
        end else if (!repeat_en) begin
          w_timer_nxt = '0;
        end else if (r_timer == C_HOLD_LAST) begin
          w_state_nxt = ST_REPEAT;
          w_timer_nxt = '0;
          w_fire      = 1'b1;
        end
      end
      ST_REPEAT: begin
        if (!w_s) begin
          w_state_nxt = ST_RELEASE_DB;
          w_timer_nxt = '0;
        end else if (!repeat_en) begin
          w_state_nxt = ST_HOLD;
          w_timer_nxt = '0;
        end else if (r_timer == C_REP_LAST) begin
          w_timer_nxt = '0;
          w_fire      = 1'b1;
        end
      end
      ST_RELEASE_DB: begin
        // A short low blip while held is treated as a glitch; the hold delay restarts.
        if (w_s) begin
          w_state_nxt = ST_HOLD;
          w_timer_nxt = '0;
        end else if (r_timer == C_DB_LAST) begin
          w_state_nxt = ST_IDLE;
          w_timer_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_timer_nxt = '0;
      end
    endcase
  end

  assign w_level_nxt = (w_state_nxt == ST_HOLD) || (w_state_nxt == ST_REPEAT) ||
                       (w_state_nxt == ST_RELEASE_DB);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync  <= '0;
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_pulse <= 1'b0;
      r_level <= 1'b0;
      r_rep   <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], btn_in};
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_pulse <= w_fire;
      r_level <= w_level_nxt;
      r_rep   <= (w_state_nxt == ST_REPEAT);
    end
  end

  assign pulse_out     = r_pulse;
  assign btn_level     = r_level;
  assign repeat_active = r_rep;

endmodule
`default_nettype wire

// File: tb/tb_btn_repeat_pulse.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_btn_repeat_pulse: directed vector bench for btn_repeat_pulse           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_btn_repeat_pulse;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_in = 1'b0;
  logic repeat_en = 1'b1;
  logic pulse_out, btn_level, repeat_active;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;

  always #5 clk = ~clk;

  btn_repeat_pulse #(
    .SYNC_STAGES (2),
    .TW          (8),
    .DEBOUNCE_CYC(4),
    .HOLD_CYC    (10),
    .REPEAT_CYC  (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .repeat_en    (repeat_en),
    .pulse_out    (pulse_out),
    .btn_level    (btn_level),
    .repeat_active(repeat_active)
  );

  // Downstream modulo-10 counter driven by the strobe.
  logic [3:0] r_cnt;
  always_ff @(posedge clk) begin
    if (!rst)           r_cnt <= 4'd0;
    else if (pulse_out) r_cnt <= (r_cnt == 4'd9) ? 4'd0 : r_cnt + 4'd1;
  end

  typedef struct {
    logic rst_n;
    logic btn;
    logic ren;
    int   cyc;
    logic p;
    logic l;
    logic r;
  } vec_t;

  localparam int N_VEC = 23;
  vec_t tbl [N_VEC];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %0d want %0d", nm, edge_n, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic b, input logic e);
    rst       = r;
    btn_in    = b;
    repeat_en = e;
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic step_chk(input string tag, input logic r, input logic b, input logic e,
                          input logic p, input logic l, input logic a);
    step(r, b, e);
    chk({tag, ".pulse"}, {7'd0, pulse_out}, {7'd0, p});
    chk({tag, ".level"}, {7'd0, btn_level}, {7'd0, l});
    chk({tag, ".rep"},   {7'd0, repeat_active}, {7'd0, a});
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    edge_n = 0;
  endtask

  initial begin
    int  n_strobe;
    logic saw_wrap;
    logic [3:0] prev_cnt;
    logic exp_p;

    // reset held with button high, then clean press held into repeat, release
    tbl[0]  = '{1'b0, 1'b0, 1'b1,  2, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1,  3, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1,  6, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1,  1, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1,  9, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1,  1, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 1'b1,  2, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1'b1,  1, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 1'b1,  2, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b1,  1, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b1,  2, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b1,  4, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b1,  6, 1'b0, 1'b0, 1'b0};
    // bounce: three high samples are rejected
    tbl[13] = '{1'b1, 1'b1, 1'b1,  3, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 1'b1,  8, 1'b0, 1'b0, 1'b0};
    // repeat disabled for 50 edges, then enabled mid-hold
    tbl[15] = '{1'b1, 1'b1, 1'b0,  6, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 1'b0,  1, 1'b1, 1'b1, 1'b0};
    tbl[17] = '{1'b1, 1'b1, 1'b0, 43, 1'b0, 1'b1, 1'b0};
    tbl[18] = '{1'b1, 1'b1, 1'b1,  9, 1'b0, 1'b1, 1'b0};
    tbl[19] = '{1'b1, 1'b1, 1'b1,  1, 1'b1, 1'b1, 1'b1};
    tbl[20] = '{1'b1, 1'b0, 1'b1,  2, 1'b0, 1'b1, 1'b1};
    tbl[21] = '{1'b1, 1'b0, 1'b1,  4, 1'b0, 1'b1, 1'b0};
    tbl[22] = '{1'b1, 1'b0, 1'b1,  3, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < N_VEC; i++) begin
      for (int c = 0; c < tbl[i].cyc; c++) begin
        step_chk($sformatf("vec%0d", i), tbl[i].rst_n, tbl[i].btn, tbl[i].ren,
                 tbl[i].p, tbl[i].l, tbl[i].r);
      end
    end

    // release glitch: low for samples 11-12 restarts the hold delay
    do_reset();
    for (int e = 1; e <= 26; e++) begin
      step_chk("glitch", 1'b1, !(e == 11 || e == 12), 1'b1,
               (e == 7 || e == 25), (e >= 7), (e >= 25));
    end

    // reset at the edge where a repeat strobe is due drops it; re-debounce after
    do_reset();
    for (int e = 1; e <= 19; e++) step(1'b1, 1'b1, 1'b1);
    for (int e = 0; e < 3; e++) step_chk("midrst", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    edge_n = 0;
    for (int e = 1; e <= 8; e++) begin
      step_chk("rearm", 1'b1, 1'b1, 1'b1, (e == 7), (e >= 7), 1'b0);
    end

    // counter integration: held 40 edges past the first strobe
    do_reset();
    n_strobe = 0;
    saw_wrap = 1'b0;
    for (int e = 1; e <= 56; e++) begin
      prev_cnt = r_cnt;
      step(1'b1, (e <= 47), 1'b1);
      exp_p = (e == 7) || (e >= 17 && e <= 47 && ((e - 17) % 3) == 0);
      chk("cnt.pulse", {7'd0, pulse_out}, {7'd0, exp_p});
      if (pulse_out) n_strobe++;
      if (prev_cnt == 4'd9 && r_cnt == 4'd0) saw_wrap = 1'b1;
      if (e == 8) chk("cnt.first", {4'd0, r_cnt}, 8'd1);
    end
    chk("cnt.strobes", n_strobe[7:0], 8'd12);
    chk("cnt.final", {4'd0, r_cnt}, 8'd2);
    chk("cnt.wrap", {7'd0, saw_wrap}, 8'd1);
    chk("cnt.level", {7'd0, btn_level}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
